wptr_full_prog: RTL and testbench
=================================

// Module: wptr_full_prog
// PURPOSE
//  Write-domain pointer and flag generator for the dual-clock FIFO, next generation.
//  Keeps the binary and Gray write pointers and a registered full flag.
//  Adds a programmable almost-full flag, a fill-level estimate and a sticky overflow flag.
//  Sits in the write clock domain. Its inputs are the writer and the 2-flop-synchronised Gray read pointer.
// PARAMETERS
//  ASIZE    4   address width; FIFO depth DEPTH = 2**ASIZE; pointers are ASIZE+1 bits
// PORTS
//  wclk          in   1        write clock; all state updates on rising edge
//  wrst          in   1        reset, synchronous, active-high
//  winc          in   1        write request; accepted only when wfull==0
//  wq2_rptr      in   ASIZE+1  read pointer (Gray), already synchronised into wclk
//  afull_thresh  in   ASIZE+1  almost-full threshold in words (0..DEPTH)
//  ovf_clr       in   1        clears woverflow
//  waddr         out  ASIZE    RAM write address (binary, low bits of write pointer)
//  wptr          out  ASIZE+1  write pointer (Gray), to read-domain synchroniser
//  wfull         out  1        FIFO full, registered
//  wafull        out  1        level >= afull_thresh, registered
//  wlevel        out  ASIZE+1  words in FIFO as seen from write side, registered
//  woverflow     out  1        sticky: a write was attempted while full
// BEHAVIOUR
//  Reset (wrst=1 at a rising edge)
//   - wbin, wptr, waddr, wlevel = 0; wfull, wafull, woverflow = 0.
//   - Reset overrides all other inputs in that cycle, including mid-burst.
//  Datapath
//   - wpush  = winc & ~wfull
//   - wbnext = wbin + wpush, modulo 2**(ASIZE+1)
//   - wgnext = (wbnext>>1) ^ wbnext
//   - Each edge: wbin<=wbnext; wptr<=wgnext.
//   - waddr = wbin[ASIZE-1:0], taken directly from the register with no extra logic.
//     So RAM write with winc&~wfull uses the current waddr.
//  Full flag
//   - Compare: wgnext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}.
//   - wfull <= result of that compare.
//   - wfull rises in the same edge that accepts the DEPTH-th word.
//   - wfull deasserts one edge after wq2_rptr shows a read.
//   - With ASIZE==1, the low slice is empty and the compare uses the top 2 bits only.
//  Level and almost-full
//   - rbin = Gray-to-binary of wq2_rptr, via an XOR prefix from the MSB down.
//   - lvl_next = wbnext - rbin, modulo 2**(ASIZE+1); range 0..DEPTH.
//   - Each edge: wlevel<=lvl_next; wafull<=(lvl_next >= afull_thresh).
//   - afull_thresh=0 -> wafull=1 from the first edge after reset.
//   - afull_thresh > DEPTH -> wafull never asserts.
//   - Level is pessimistic, because the read pointer lags by synchroniser latency.
//     It may overstate the fill, but never understates it.
//   - Invariant: wfull=1 implies wlevel==DEPTH.
//  Overflow
//   - winc&wfull at an edge sets woverflow. The pointer does not move.
//   - ovf_clr clears woverflow.
//   - Set wins over clear in the same cycle.
//  Simultaneous events
//   - A push while wq2_rptr advances in the same cycle uses the new wq2_rptr in all compares.
//   - A fill of DEPTH-1 plus push plus read gives wfull=0 and wlevel=DEPTH-1+1-1.
// TESTING  (ASIZE=4, DEPTH=16)
//  1. Reset, wq2_rptr=0, 16 winc pulses.
//     -> wfull=1 after 16th edge; wptr=5'b11000; waddr=0; wlevel=16.
//  2. From (1), a 17th winc.
//     -> wptr unchanged; woverflow=1.
//     ovf_clr pulse -> woverflow=0. ovf_clr and winc in the same cycle while full -> woverflow stays 1.
//  3. From (1), drive wq2_rptr=gray(1)=5'b00001.
//     -> next edge wfull=0, wlevel=15; one winc -> wfull=1 again, wptr=gray(17)=5'b11001.
//  4. afull_thresh=12, write 11 words.
//     -> wafull=0; 12th word -> wafull=1 on the same edge; one read sync'd -> wafull=0.
//  5. Wrap: stream 40 writes with wq2_rptr tracking 2 words behind.
//     -> wfull never 1; waddr wraps 15->0; wptr sequence Gray (one bit change per push).
//  6. wrst=1 mid-burst at wlevel=9 with woverflow=1.
//     -> all outputs 0 next edge; winc during reset ignored.

Source files
------------

// File: rtl/wptr_full_prog.sv
// Write-domain pointer and flag generator for a dual-clock FIFO.
// Holds binary/Gray write pointers, full and almost-full flags, a fill level and a sticky overflow flag.
module wptr_full_prog #(
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2_rptr,
    input  logic [ASIZE:0]   afull_thresh,
    input  logic             ovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             wafull,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    // The full pattern is the read pointer with its top two Gray bits inverted.
    localparam logic [ASIZE:0] FULL_MASK = (ASIZE+1)'(3) << (ASIZE - 1);

    logic [ASIZE:0] wbin_q, wbin_d;
    logic [ASIZE:0] wptr_q, wptr_d;
    logic           wfull_q, wfull_d;
    logic           wafull_q, wafull_d;
    logic [ASIZE:0] wlevel_q, wlevel_d;
    logic           woverflow_q, woverflow_d;

    logic           wpush;
    logic [ASIZE:0] rbin;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    always_comb begin
        wpush       = winc & ~wfull_q;
        wbin_d      = wbin_q + {{ASIZE{1'b0}}, wpush};
        wptr_d      = (wbin_d >> 1) ^ wbin_d;
        wfull_d     = (wptr_d == (wq2_rptr ^ FULL_MASK));
        wlevel_d    = wbin_d - rbin;
        wafull_d    = (wlevel_d >= afull_thresh);
        woverflow_d = (winc & wfull_q) | (woverflow_q & ~ovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q      <= '0;
            wptr_q      <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            wlevel_q    <= '0;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_q      <= wptr_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            wlevel_q    <= wlevel_d;
            woverflow_q <= woverflow_d;
        end
    end

    assign waddr     = wbin_q[ASIZE-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wlevel    = wlevel_q;
    assign woverflow = woverflow_q;

endmodule

// File: tb/tb_wptr_full_prog.sv
// Directed self-checking bench for wptr_full_prog with ASIZE=4 (DEPTH=16).
module tb_wptr_full_prog;

    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             wclk = 1'b0;
    logic             wrst;
    logic             winc;
    logic [ASIZE:0]   wq2_rptr;
    logic [ASIZE:0]   afull_thresh;
    logic             ovf_clr;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             wafull;
    logic [ASIZE:0]   wlevel;
    logic             woverflow;

    int checks = 0;
    int errors = 0;

    wptr_full_prog #(.ASIZE(ASIZE)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
        .afull_thresh(afull_thresh), .ovf_clr(ovf_clr), .waddr(waddr),
        .wptr(wptr), .wfull(wfull), .wafull(wafull), .wlevel(wlevel),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [ASIZE:0] gray(input int b);
        logic [ASIZE:0] v;
        v = b[ASIZE:0];
        return v ^ (v >> 1);
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1; winc = 1'b0; ovf_clr = 1'b0; wq2_rptr = '0;
        tick();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        afull_thresh = 5'd0;
        do_reset();
        checks++;
        if ({wptr, waddr, wfull, wafull, wlevel, woverflow} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got wptr=%b waddr=%0d wfull=%b wafull=%b wlevel=%0d wovf=%b, want all 0",
                     wptr, waddr, wfull, wafull, wlevel, woverflow);
        end
        tick();
        checks++;
        if (wafull !== 1'b1 || wlevel !== 5'd0) begin
            errors++;
            $display("[TB] FAIL thresh_zero: got wafull=%b wlevel=%0d, want 1 and 0", wafull, wlevel);
        end
    endtask

    task automatic test_fill();
        afull_thresh = 5'd20;
        do_reset();
        winc = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            checks++;
            if (wlevel !== 5'(i) || wfull !== (i == DEPTH) || wafull !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fill_%0d: got wlevel=%0d wfull=%b wafull=%b, want %0d %b 0",
                         i, wlevel, wfull, wafull, i, (i == DEPTH));
            end
        end
        winc = 1'b0;
        checks++;
        if (wptr !== 5'b11000 || waddr !== 4'd0) begin
            errors++;
            $display("[TB] FAIL fill_ptr: got wptr=%b waddr=%0d, want 11000 0", wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        tick();
        winc = 1'b0;
        checks++;
        if (wptr !== 5'b11000 || woverflow !== 1'b1 || wlevel !== 5'd16 || wfull !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: got wptr=%b wovf=%b wlevel=%0d wfull=%b, want 11000 1 16 1",
                     wptr, woverflow, wlevel, wfull);
        end
        ovf_clr = 1'b1;
        tick();
        checks++;
        if (woverflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clr: got wovf=%b, want 0", woverflow);
        end
        winc = 1'b1;
        tick();
        winc = 1'b0; ovf_clr = 1'b0;
        checks++;
        if (woverflow !== 1'b1 || wptr !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL ovf_set_wins: got wovf=%b wptr=%b, want 1 11000", woverflow, wptr);
        end
        tick();
        checks++;
        if (woverflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got wovf=%b, want 1", woverflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_read();
        wq2_rptr = 5'b00001;
        tick();
        checks++;
        if (wfull !== 1'b0 || wlevel !== 5'd15) begin
            errors++;
            $display("[TB] FAIL read_unfull: got wfull=%b wlevel=%0d, want 0 15", wfull, wlevel);
        end
        winc = 1'b1;
        tick();
        winc = 1'b0;
        checks++;
        if (wfull !== 1'b1 || wptr !== 5'b11001 || wlevel !== 5'd16 || waddr !== 4'd1) begin
            errors++;
            $display("[TB] FAIL refill: got wfull=%b wptr=%b wlevel=%0d waddr=%0d, want 1 11001 16 1",
                     wfull, wptr, wlevel, waddr);
        end
    endtask

    task automatic test_afull();
        afull_thresh = 5'd12;
        do_reset();
        winc = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (wafull !== (i >= 12) || wlevel !== 5'(i)) begin
                errors++;
                $display("[TB] FAIL afull_%0d: got wafull=%b wlevel=%0d, want %b %0d",
                         i, wafull, wlevel, (i >= 12), i);
            end
        end
        winc = 1'b0;
        wq2_rptr = gray(1);
        tick();
        checks++;
        if (wafull !== 1'b0 || wlevel !== 5'd11) begin
            errors++;
            $display("[TB] FAIL afull_drop: got wafull=%b wlevel=%0d, want 0 11", wafull, wlevel);
        end
    endtask

    task automatic test_simultaneous();
        afull_thresh = 5'd20;
        do_reset();
        winc = 1'b1;
        repeat (15) tick();
        wq2_rptr = gray(1);
        tick();
        winc = 1'b0;
        checks++;
        if (wfull !== 1'b0 || wlevel !== 5'd15 || wptr !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL push_and_read: got wfull=%b wlevel=%0d wptr=%b, want 0 15 11000",
                     wfull, wlevel, wptr);
        end
    endtask

    task automatic test_wrap();
        logic [ASIZE:0] prev;
        int rb;
        afull_thresh = 5'd17;
        do_reset();
        prev = wptr;
        winc = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rb = (n >= 2) ? n - 2 : 0;
            wq2_rptr = gray(rb);
            tick();
            checks++;
            if (wfull !== 1'b0 || wafull !== 1'b0 || waddr !== 4'((n + 1) % 16) ||
                wptr !== gray(n + 1) || wlevel !== 5'(n + 1 - rb) || $countones(wptr ^ prev) != 1) begin
                errors++;
                $display("[TB] FAIL wrap_%0d: got wfull=%b waddr=%0d wptr=%b wlevel=%0d prev=%b, want 0 %0d %b %0d",
                         n + 1, wfull, waddr, wptr, wlevel, prev, (n + 1) % 16, gray(n + 1), n + 1 - rb);
            end
            prev = wptr;
        end
        winc = 1'b0;
    endtask

    task automatic test_reset_mid();
        afull_thresh = 5'd20;
        do_reset();
        winc = 1'b1;
        repeat (17) tick();
        winc = 1'b0;
        wq2_rptr = gray(7);
        tick();
        checks++;
        if (wlevel !== 5'd9 || woverflow !== 1'b1 || wfull !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset: got wlevel=%0d wovf=%b wfull=%b, want 9 1 0", wlevel, woverflow, wfull);
        end
        wrst = 1'b1; winc = 1'b1; wq2_rptr = '0; afull_thresh = 5'd0;
        tick();
        checks++;
        if ({wptr, waddr, wfull, wafull, wlevel, woverflow} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got wptr=%b waddr=%0d wfull=%b wafull=%b wlevel=%0d wovf=%b, want all 0",
                     wptr, waddr, wfull, wafull, wlevel, woverflow);
        end
        wrst = 1'b0; winc = 1'b0;
        tick();
        checks++;
        if (wafull !== 1'b1 || wlevel !== 5'd0 || waddr !== 4'd0) begin
            errors++;
            $display("[TB] FAIL post_reset: got wafull=%b wlevel=%0d waddr=%0d, want 1 0 0", wafull, wlevel, waddr);
        end
    endtask

    initial begin
        wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; afull_thresh = '0; ovf_clr = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_read();
        test_afull();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
